// File: rtl/multiword_add_sequencer.sv
// Multiword add/subtract sequencer.
// Accepts one W-bit add or subtract operation through a valid/ready handshake.
// The operation is evaluated one 4-bit nibble per cycle through a single
// ripple-carry slice, least significant nibble first. The result is then held
// under valid/ready backpressure until the consumer takes it.
module multiword_add_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    logic [1:0]    state_q;
    logic [IW-1:0] idx_q;
    logic          carry_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;      // already inverted when subtracting
    logic [W-1:0]  sum_q;
    logic          cout_q;
    logic          ovf_q;

    logic [3:0]    slice_a;
    logic [3:0]    slice_b;
    logic [3:0]    slice_sum;
    logic          slice_cout;
    logic          slice_c_msb; // carry into bit 3 of the slice

    logic          accept;
    logic          release_result;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    assign accept         = in_valid && in_ready;
    assign release_result = out_valid && out_ready;

    // One 4-bit bitwise ripple-carry slice on the currently selected nibble.
    always_comb begin
        logic cv;
        // NOTE: every output of a combinational block gets a default before
        // any conditional or loop, so no path can leave it unassigned (latch).
        slice_a     = a_q[4*idx_q +: 4];
        slice_b     = b_q[4*idx_q +: 4];
        slice_sum   = '0;
        slice_c_msb = 1'b0;
        cv          = carry_q;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                slice_c_msb = cv;
            end
            slice_sum[i] = slice_a[i] ^ slice_b[i] ^ cv;
            cv           = (slice_a[i] & slice_b[i]) | (cv & (slice_a[i] ^ slice_b[i]));
        end
        slice_cout = cv;
    end

    // Operand capture; only ever loaded on acceptance, so no reset needed.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all clocked state so every
        // register samples pre-edge values regardless of statement order.
        if (accept) begin
            a_q <= a;
            b_q <= b ^ {W{sub}};
        end
    end

    // Control FSM, carry chain and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        carry_q <= sub ? 1'b1 : cin;
                        idx_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q[4*idx_q +: 4] <= slice_sum;
                    carry_q             <= slice_cout;
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= slice_cout;
                        ovf_q   <= slice_c_msb ^ slice_cout;
                        idx_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (release_result) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
